// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Control FSM for a multicycle MIPS-style datapath. It sequences fetch, decode,
// memory access, ALU execution, branches and jumps. It also supervises memory
// handshakes with a stall watchdog, and it latches a sticky error that only
// reset clears.
//
// Parameters
//   WAIT_LIMIT  consecutive memory stall cycles tolerated (0 = no watchdog)
//   ENABLE_JAL  1 = jal supported, 0 = jal decodes as an illegal opcode
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   op, funct           instruction register fields
//   mem_ready           memory completes the current request this cycle
//   mem_req, mem_write  memory request / write qualifier
//   iord                memory address select (0 PC, 1 ALU result register)
//   ir_write, pc_write  instruction register / unconditional PC load
//   branch              00 none, 01 beq, 11 bne
//   pc_src              00 ALU result, 01 ALU output register, 10 jump target
//   alu_src_a           0 PC, 1 register A
//   alu_src_b           00 B, 01 4, 10 imm, 11 imm<<2
//   shamt_sel           ALU A operand is the zero-extended shamt
//   alu_op              00 add, 01 sub, 10 funct-directed
//   reg_write, reg_dst  register write enable, 0 rt / 1 rd
//   reg_ra              destination register is $31
//   mem_to_reg          write-back data comes from the memory data register
//   pc_to_reg           write-back data is the return address
//   instr_done          pulse on the final cycle of each instruction
//   err, err_code       sticky error, 01 illegal opcode / 10 memory timeout
//
// All outputs are decoded from the current state. They are not registered,
// because the FETCH and MEM_WRITE strobes must follow mem_ready in the same
// cycle, and reset must silence every output while it is high.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int WAIT_LIMIT = 16,
  parameter int ENABLE_JAL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] branch,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       shamt_sel,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       reg_ra,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       instr_done,
  output logic       err,
  output logic [1:0] err_code
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  // The counter only has to reach WAIT_LIMIT. Keep it at least one bit wide.
  localparam int            CW       = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT    = CW'(WAIT_LIMIT);
  localparam logic          WATCHDOG = (WAIT_LIMIT > 0);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    ADDI_EX   = 4'd9,
    ADDI_WB   = 4'd10,
    JUMP      = 4'd11,
    JAL       = 4'd12,
    ERROR     = 4'd13
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_next;
  logic [CW-1:0] wait_inc;
  logic [1:0]    fault_code;
  logic [1:0]    fault_code_next;
  logic          mem_state;
  logic          stall;
  logic          timeout;

  // Memory handshake bookkeeping shared by the next-state logic and the counter
  always_comb begin
    mem_state = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
    stall     = mem_state && !mem_ready;
    wait_inc  = wait_cnt + CW'(1'b1);
    // A timeout fires on the stall cycle that brings the count up to the limit.
    // A mem_ready in that cycle is not a stall, so completion always wins.
    timeout   = WATCHDOG && stall && (wait_inc == LIMIT);
    if (WATCHDOG && stall && !timeout) begin
      // A stall never changes state, so the count only grows within one request.
      wait_cnt_next = wait_inc;
    end else begin
      wait_cnt_next = '0;
    end
  end

  // State, stall counter and error-code registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      wait_cnt   <= '0;
      fault_code <= 2'b00;
    end else begin
      state      <= next_state;
      wait_cnt   <= wait_cnt_next;
      fault_code <= fault_code_next;
    end
  end

  // Next-state selection
  always_comb begin
    next_state      = state;
    fault_code_next = fault_code;
    case (state)
      FETCH: begin
        if (mem_ready) begin
          next_state = DECODE;
        end else if (timeout) begin
          next_state      = ERROR;
          fault_code_next = CODE_TIMEOUT;
        end else begin
          next_state = FETCH;
        end
      end
      DECODE: begin
        casez (op)
          OP_LW, OP_SW:    next_state = MEM_ADR;
          OP_RTYPE:        next_state = EXECUTE;
          OP_BEQ, OP_BNE:  next_state = BRANCH;
          6'b00100?:       next_state = ADDI_EX;   // addi and addiu
          OP_J:            next_state = JUMP;
          OP_JAL: begin
            if (ENABLE_JAL != 0) begin
              next_state = JAL;
            end else begin
              next_state      = ERROR;
              fault_code_next = CODE_ILLEGAL;
            end
          end
          default: begin
            next_state      = ERROR;
            fault_code_next = CODE_ILLEGAL;
          end
        endcase
      end
      MEM_ADR: begin
        // Only lw and sw reach here, and op stays stable until completion.
        if (op == OP_SW) begin
          next_state = MEM_WRITE;
        end else begin
          next_state = MEM_READ;
        end
      end
      MEM_READ: begin
        if (mem_ready) begin
          next_state = MEM_WB;
        end else if (timeout) begin
          next_state      = ERROR;
          fault_code_next = CODE_TIMEOUT;
        end else begin
          next_state = MEM_READ;
        end
      end
      MEM_WRITE: begin
        if (mem_ready) begin
          next_state = FETCH;
        end else if (timeout) begin
          next_state      = ERROR;
          fault_code_next = CODE_TIMEOUT;
        end else begin
          next_state = MEM_WRITE;
        end
      end
      EXECUTE:  next_state = ALU_WB;
      ADDI_EX:  next_state = ADDI_WB;
      MEM_WB, ALU_WB, BRANCH, ADDI_WB, JUMP, JAL: next_state = FETCH;
      ERROR:    next_state = ERROR;                // held until reset
      default: begin
        // Unreachable encodings recover into a clean fetch.
        next_state      = FETCH;
        fault_code_next = 2'b00;
      end
    endcase
  end

  // Control word decode; everything not named for a state stays zero
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 2'b00;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    shamt_sel  = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    reg_ra     = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    instr_done = 1'b0;
    err        = 1'b0;
    err_code   = 2'b00;
    if (reset) begin
      // While reset is high the datapath sees an all-zero control word.
      mem_req = 1'b0;
      err     = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          // IR and PC load only when the fetched word actually arrives.
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b = 2'b11;
        end
        MEM_ADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_READ: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        MEM_WRITE: begin
          mem_req    = 1'b1;
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          // funct 000000 is sll; the shift amount replaces register A.
          shamt_sel = (funct == 6'b000000);
        end
        ALU_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b01;
          pc_src     = 2'b01;
          branch     = (op == OP_BNE) ? 2'b11 : 2'b01;
          instr_done = 1'b1;
        end
        ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        JUMP: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
        end
        JAL: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          reg_write  = 1'b1;
          reg_ra     = 1'b1;
          pc_to_reg  = 1'b1;
          instr_done = 1'b1;
        end
        ERROR: begin
          err      = 1'b1;
          err_code = fault_code;
        end
        default: begin
          err = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Two units run side by side on the same stimulus:
//   unit_a : WAIT_LIMIT=4,  ENABLE_JAL=1
//   unit_b : WAIT_LIMIT=16, ENABLE_JAL=0
// The reference model treats each instruction as a list of micro-steps. Each
// step has a control word, an optional word added when memory completes, and
// a flag marking it as a memory step. Decoding an opcode expands into that
// list. The whole 24-bit control word of each unit is compared every cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       mem_ready;

  logic [23:0] obs [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_unit
    logic       mem_req, mem_write, iord, ir_write, pc_write;
    logic [1:0] branch, pc_src, alu_src_b, alu_op, err_code;
    logic       alu_src_a, shamt_sel, reg_write, reg_dst, reg_ra;
    logic       mem_to_reg, pc_to_reg, instr_done, err;

    multicycle_control_unit #(
      .WAIT_LIMIT((g == 0) ? 4 : 16),
      .ENABLE_JAL((g == 0) ? 1 : 0)
    ) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
      .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .shamt_sel(shamt_sel), .alu_op(alu_op), .reg_write(reg_write),
      .reg_dst(reg_dst), .reg_ra(reg_ra), .mem_to_reg(mem_to_reg),
      .pc_to_reg(pc_to_reg), .instr_done(instr_done), .err(err),
      .err_code(err_code)
    );

    assign obs[g] = {mem_req, mem_write, iord, ir_write, pc_write, branch,
                     pc_src, alu_src_a, alu_src_b, shamt_sel, alu_op,
                     reg_write, reg_dst, reg_ra, mem_to_reg, pc_to_reg,
                     instr_done, err, err_code};
  end

  // Control-word fields, in the bit layout packed above
  localparam logic [23:0] MREQ   = 24'h80_0000;
  localparam logic [23:0] MWR    = 24'h40_0000;
  localparam logic [23:0] IORD   = 24'h20_0000;
  localparam logic [23:0] IRW    = 24'h10_0000;
  localparam logic [23:0] PCW    = 24'h08_0000;
  localparam logic [23:0] BR_EQ  = 24'h02_0000;   // branch = 01
  localparam logic [23:0] BR_NE  = 24'h06_0000;   // branch = 11
  localparam logic [23:0] PCS_AO = 24'h00_8000;   // pc_src = 01
  localparam logic [23:0] PCS_J  = 24'h01_0000;   // pc_src = 10
  localparam logic [23:0] SRCA   = 24'h00_4000;
  localparam logic [23:0] SRCB_4 = 24'h00_1000;   // alu_src_b = 01
  localparam logic [23:0] SRCB_I = 24'h00_2000;   // alu_src_b = 10
  localparam logic [23:0] SRCB_S = 24'h00_3000;   // alu_src_b = 11
  localparam logic [23:0] SHAMT  = 24'h00_0800;
  localparam logic [23:0] ALU_SB = 24'h00_0200;   // alu_op = 01
  localparam logic [23:0] ALU_FN = 24'h00_0400;   // alu_op = 10
  localparam logic [23:0] REGW   = 24'h00_0100;
  localparam logic [23:0] RDST   = 24'h00_0080;
  localparam logic [23:0] RA     = 24'h00_0040;
  localparam logic [23:0] M2R    = 24'h00_0020;
  localparam logic [23:0] PC2R   = 24'h00_0010;
  localparam logic [23:0] DONE   = 24'h00_0008;
  localparam logic [23:0] ERRB   = 24'h00_0004;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] ADDIU = 6'b001001, J = 6'b000010, JALOP = 6'b000011;

  typedef struct packed {
    logic [23:0] base;
    logic [23:0] extra;     // added in the cycle memory completes
    logic        mem;       // waits for mem_ready
    logic        fetch;
    logic        decode;
  } step_t;

  step_t      plan [2][6];
  int         pidx [2];
  int         plen [2];
  int         stall_n [2];
  int         err_age [2];
  bit         errd [2];
  logic [1:0] ecode [2];
  int         lim [2] = '{4, 16};
  bit         jal_ok [2] = '{1'b1, 1'b0};

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", tag, cycle, got, want);
    end
  endtask

  function automatic step_t mk(input logic [23:0] b, input logic [23:0] x,
                               input logic m, input logic f, input logic d);
    step_t s;
    s.base = b; s.extra = x; s.mem = m; s.fetch = f; s.decode = d;
    return s;
  endfunction

  task automatic push(input int k, input step_t s);
    plan[k][plen[k]] = s;
    plen[k]++;
  endtask

  task automatic load_fetch(input int k);
    plen[k] = 0;
    pidx[k] = 0;
    push(k, mk(MREQ | SRCB_4, IRW | PCW, 1'b1, 1'b1, 1'b0));
    push(k, mk(SRCB_S, 24'h0, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic fail_model(input int k, input logic [1:0] c);
    errd[k] = 1'b1; ecode[k] = c; err_age[k] = 0;
  endtask

  // Instruction-level expansion of the opcode into its remaining steps
  task automatic expand(input int k, input logic [5:0] o, input logic [5:0] f);
    plen[k] = 0;
    pidx[k] = 0;
    case (o)
      LW: begin
        push(k, mk(SRCA | SRCB_I, 24'h0, 1'b0, 1'b0, 1'b0));
        push(k, mk(MREQ | IORD, 24'h0, 1'b1, 1'b0, 1'b0));
        push(k, mk(REGW | M2R | DONE, 24'h0, 1'b0, 1'b0, 1'b0));
      end
      SW: begin
        push(k, mk(SRCA | SRCB_I, 24'h0, 1'b0, 1'b0, 1'b0));
        push(k, mk(MREQ | MWR | IORD, DONE, 1'b1, 1'b0, 1'b0));
      end
      RT: begin
        push(k, mk(SRCA | ALU_FN | ((f == 6'd0) ? SHAMT : 24'h0), 24'h0, 1'b0, 1'b0, 1'b0));
        push(k, mk(REGW | RDST | DONE, 24'h0, 1'b0, 1'b0, 1'b0));
      end
      BEQ: push(k, mk(SRCA | ALU_SB | PCS_AO | BR_EQ | DONE, 24'h0, 1'b0, 1'b0, 1'b0));
      BNE: push(k, mk(SRCA | ALU_SB | PCS_AO | BR_NE | DONE, 24'h0, 1'b0, 1'b0, 1'b0));
      ADDI, ADDIU: begin
        push(k, mk(SRCA | SRCB_I, 24'h0, 1'b0, 1'b0, 1'b0));
        push(k, mk(REGW | DONE, 24'h0, 1'b0, 1'b0, 1'b0));
      end
      J: push(k, mk(PCW | PCS_J | DONE, 24'h0, 1'b0, 1'b0, 1'b0));
      JALOP: begin
        if (jal_ok[k]) push(k, mk(PCW | PCS_J | REGW | RA | PC2R | DONE, 24'h0, 1'b0, 1'b0, 1'b0));
        else fail_model(k, 2'b01);
      end
      default: fail_model(k, 2'b01);
    endcase
  endtask

  function automatic logic [23:0] model_out(input int k, input logic r, input logic rdy);
    step_t s;
    if (r) return 24'h0;
    if (errd[k]) return ERRB | {22'h0, ecode[k]};
    s = plan[k][pidx[k]];
    return s.base | ((s.mem && rdy) ? s.extra : 24'h0);
  endfunction

  task automatic advance(input int k, input logic r, input logic rdy,
                         input logic [5:0] o, input logic [5:0] f);
    step_t s;
    if (r) begin
      load_fetch(k);
      stall_n[k] = 0; errd[k] = 1'b0; ecode[k] = 2'b00; err_age[k] = 0;
    end else if (errd[k]) begin
      err_age[k]++;
    end else begin
      s = plan[k][pidx[k]];
      if (s.mem && !rdy) begin
        stall_n[k]++;
        if (lim[k] > 0 && stall_n[k] >= lim[k]) fail_model(k, 2'b10);
      end else begin
        stall_n[k] = 0;
        if (s.decode) expand(k, o, f);
        else if (pidx[k] + 1 < plen[k]) pidx[k]++;
        else load_fetch(k);
      end
    end
  endtask

  function automatic bit at_fetch(input int k);
    return errd[k] || plan[k][pidx[k]].fetch;
  endfunction

  task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f, input logic rdy);
    reset = r; op = o; funct = f; mem_ready = rdy;
    @(negedge clk);
    check_eq("unit_a", obs[0], model_out(0, r, rdy));
    check_eq("unit_b", obs[1], model_out(1, r, rdy));
    advance(0, r, rdy, o, f);
    advance(1, r, rdy, o, f);
    cycle++;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ops [10] = '{LW, SW, RT, RT, BEQ, BNE, ADDI, ADDIU, J, JALOP};

  initial begin
    logic [5:0] cur_op, cur_fn;
    logic       r, rdy;
    int         burst;
    for (int k = 0; k < 2; k++) begin
      load_fetch(k);
      stall_n[k] = 0; errd[k] = 1'b0; ecode[k] = 2'b00; err_age[k] = 0;
    end
    reset = 1'b1; op = 6'd0; funct = 6'd0; mem_ready = 1'b0;
    @(posedge clk); #1;

    // Reset state, then add: FETCH, DECODE, EXECUTE, ALU_WB
    cyc(1'b1, RT, 6'b100000, 1'b0);
    cyc(1'b1, RT, 6'b100000, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, RT, 6'b100000, 1'b1);
    // lw with three stall cycles in MEM_READ, done on cycle 8
    for (int i = 0; i < 8; i++) cyc(1'b0, LW, 6'd5, (i >= 3 && i <= 5) ? 1'b0 : 1'b1);
    // bne, then sll
    for (int i = 0; i < 3; i++) cyc(1'b0, BNE, 6'd0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, RT, 6'd0, 1'b1);
    // sw with two write stalls, beq, addi, addiu, j
    for (int i = 0; i < 6; i++) cyc(1'b0, SW, 6'd0, (i == 3 || i == 4) ? 1'b0 : 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, BEQ, 6'd0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, ADDI, 6'd0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, ADDIU, 6'd0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, J, 6'd0, 1'b1);
    // jal: legal on unit_a, illegal and sticky on unit_b
    for (int i = 0; i < 24; i++) cyc(1'b0, JALOP, 6'd0, 1'b1);
    cyc(1'b1, JALOP, 6'd0, 1'b1);
    // FETCH stalled: unit_a times out after 4 stalls, unit_b keeps waiting
    for (int i = 0; i < 8; i++) cyc(1'b0, RT, 6'd0, 1'b0);
    cyc(1'b1, RT, 6'd0, 1'b0);
    // Boundary: 3 stalls then ready is no timeout on unit_a
    for (int i = 0; i < 6; i++) cyc(1'b0, J, 6'd0, (i < 3) ? 1'b0 : 1'b1);
    // unit_b: 15 stalls then ready is no timeout; 16 stalls is
    for (int i = 0; i < 19; i++) cyc(1'b0, BEQ, 6'd0, (i < 15) ? 1'b0 : 1'b1);
    cyc(1'b1, RT, 6'd0, 1'b1);
    for (int i = 0; i < 18; i++) cyc(1'b0, RT, 6'd0, 1'b0);
    cyc(1'b1, RT, 6'd0, 1'b1);
    // Reset mid-MEM_WRITE, then a clean fetch
    for (int i = 0; i < 5; i++) cyc(1'b0, SW, 6'd0, (i < 3) ? 1'b1 : 1'b0);
    cyc(1'b1, SW, 6'd0, 1'b0);
    cyc(1'b1, SW, 6'd0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, SW, 6'd0, 1'b0);
    cyc(1'b1, SW, 6'd0, 1'b1);
    // Illegal opcode on both units
    for (int i = 0; i < 5; i++) cyc(1'b0, 6'b111111, 6'd0, 1'b1);
    cyc(1'b1, RT, 6'd0, 1'b1);

    // Randomised phase
    cur_op = RT; cur_fn = 6'd0; burst = 0;
    for (int n = 0; n < 4000; n++) begin
      r = ((errd[0] && err_age[0] >= 20) || (errd[1] && err_age[1] >= 20) ||
           ($urandom % 200 == 0)) ? 1'b1 : 1'b0;
      if (at_fetch(0) && at_fetch(1)) begin
        if ($urandom % 12 == 0) cur_op = 6'($urandom);
        else cur_op = ops[$urandom % 10];
        case ($urandom % 4)
          0:       cur_fn = 6'd0;
          1:       cur_fn = 6'b100000;
          default: cur_fn = 6'($urandom);
        endcase
      end
      if (burst > 0) begin
        rdy = 1'b0;
        burst--;
      end else begin
        rdy = ($urandom % 3 != 0) ? 1'b1 : 1'b0;
        if ($urandom % 30 == 0) burst = $urandom_range(3, 18);
      end
      cyc(r, cur_op, cur_fn, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 16, max consecutive memory stall cycles before timeout; 0 disables timeout.
REQ-002 SHALL have parameter ENABLE_JAL, default 1; when 0, jal (op 000011) is illegal.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  6  opcode from instruction register; stable from DECODE to instruction completion.
- funct  in  6  function field from instruction register.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_write  out  1  request is a write; valid with mem_req.
- iord  out  1  address select: 0 = PC, 1 = ALU result register.
- ir_write  out  1  load instruction register.
- pc_write  out  1  unconditional PC load.
- branch  out  2  00 none, 01 beq (take on zero), 11 bne (take on !zero).
- pc_src  out  2  00 ALU result, 01 ALU output register, 10 jump target.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2.
- shamt_sel  out  1  ALU A operand is zero-extended shamt.
- alu_op  out  2  00 add, 01 sub, 10 use funct.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  0 = rt, 1 = rd.
- reg_ra  out  1  destination is $31.
- mem_to_reg  out  1  write-back data from memory data register.
- pc_to_reg  out  1  write-back data is PC (return address).
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- err  out  1  sticky error flag.
- err_code  out  2  00 none, 01 illegal opcode, 10 memory timeout.

Function
REQ-004 SHALL implement states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, ADDI_EX, ADDI_WB, JUMP, JAL, ERROR.
REQ-005 SHALL drive every output not listed for a state to 0; no x values are driven.
REQ-006 FETCH SHALL drive mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
- FETCH SHALL assert ir_write and pc_write only in the mem_ready cycle, then go to DECODE; otherwise it stays in FETCH.
REQ-007 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00, and branch on op:
- lw/sw -> MEM_ADR; op 000000 -> EXECUTE; beq/bne -> BRANCH
- addi/addiu (00100?) -> ADDI_EX; j -> JUMP; jal -> JAL
- any other op -> ERROR with err_code 01.
REQ-008 MEM_ADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_READ (lw) or MEM_WRITE (sw).
REQ-009 MEM_READ SHALL drive mem_req=1, iord=1 and go to MEM_WB on mem_ready; MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-010 MEM_WRITE SHALL drive mem_req=1, mem_write=1, iord=1 and go to FETCH on mem_ready.
REQ-011 EXECUTE SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, and shamt_sel=1 when funct==000000; ALU_WB SHALL drive reg_write=1, reg_dst=1.
REQ-012 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=01 (beq) or 11 (bne).
REQ-013 ADDI_EX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00; ADDI_WB SHALL drive reg_write=1, reg_dst=0.
REQ-014 JUMP SHALL drive pc_write=1, pc_src=10; JAL SHALL additionally drive reg_write=1, reg_ra=1, pc_to_reg=1.
REQ-015 MEM_WB, ALU_WB, BRANCH, ADDI_WB, JUMP and JAL SHALL pulse instr_done, then go to FETCH; MEM_WRITE SHALL pulse instr_done only in its mem_ready cycle.
REQ-016 SHALL keep a wait counter:
- increments each cycle with mem_req=1 and mem_ready=0; clears on mem_ready or state change.
- when it reaches WAIT_LIMIT (WAIT_LIMIT>0), the next state SHALL be ERROR with err_code 10.
- mem_ready in that same cycle wins; no error.
REQ-017 ERROR SHALL drive err=1 and hold err_code, with all other outputs 0, until reset.

Reset
REQ-018 While reset=1 all outputs SHALL be 0; on the edge it is sampled, state SHALL become FETCH and the wait counter, err and err_code SHALL clear.
REQ-019 Reset SHALL take priority over every transition, including in mid-memory-request and in ERROR; the first cycle after reset deasserts SHALL show mem_req=1, iord=0.

Verification
REQ-020 add (op 000000, funct 100000), mem_ready=1 in FETCH -> FETCH, DECODE, EXECUTE (alu_op=10), ALU_WB (reg_write=1, reg_dst=1, instr_done=1); 4 cycles.
REQ-021 lw with mem_ready low for 3 cycles in MEM_READ -> mem_req/iord held 3 cycles, MEM_WB then has reg_write=1, mem_to_reg=1; instr_done on cycle 8.
REQ-022 bne (000101) -> BRANCH with branch=11, pc_src=01, alu_op=01; sll (funct 000000) -> EXECUTE with shamt_sel=1.
REQ-023 jal with ENABLE_JAL=1 -> JAL with pc_write, reg_write, reg_ra, pc_to_reg =1; with ENABLE_JAL=0 -> ERROR, err=1, err_code=01, sticky for 20 cycles.
REQ-024 WAIT_LIMIT=4, mem_ready held 0 in FETCH -> ERROR after 4 stall cycles, err_code=10; reset pulse -> FETCH, err=0.
REQ-025 Reset asserted mid-MEM_WRITE -> outputs 0 during reset, mem_write never asserted after release, FETCH next.
